// File: rtl/button_press_gen_pkg.sv
// ============================================================================
// button_press_gen_pkg : state encodings and defaults for button_press_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

package button_press_gen_pkg;

    localparam int DEFAULT_CNT_W = 24;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_BOUNCE_IN  = 3'd1;
    localparam logic [2:0] ST_HOLD       = 3'd2;
    localparam logic [2:0] ST_BOUNCE_OUT = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;
    localparam logic [2:0] ST_FINISH     = 3'd5;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        BOUNCE_IN  = ST_BOUNCE_IN,
        HOLD       = ST_HOLD,
        BOUNCE_OUT = ST_BOUNCE_OUT,
        GAP        = ST_GAP,
        FINISH     = ST_FINISH
    } state_t;

endpackage

`default_nettype wire

// File: rtl/button_press_gen_seg_timer.sv
// ============================================================================
// button_press_gen_seg_timer : loadable down-counter, zero flag marks last cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_press_gen_seg_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/button_press_gen.sv
// ============================================================================
// button_press_gen : bouncing push-button waveform generator
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_press_gen
    import button_press_gen_pkg::*;
#(
    parameter int CNT_W          = DEFAULT_CNT_W,
    parameter int BOUNCE_TOGGLES = 4,
    parameter int BOUNCE_PERIOD  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] hold_cycles,
    input  logic [CNT_W-1:0] gap_cycles,
    input  logic [3:0]       num_presses,
    output logic             button,
    output logic             press_active,
    output logic             busy,
    output logic             done
);

    localparam logic [4:0]       LAST_SEG  = 5'(2 * BOUNCE_TOGGLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(BOUNCE_PERIOD - 1);

    state_t           state;
    logic [4:0]       seg_idx;
    logic [3:0]       presses_left;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] hold_m1;
    logic [CNT_W-1:0] gap_m1;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    // Timer holds (remaining - 1); a zero length command behaves as one cycle.
    assign hold_m1 = (hold_q == '0) ? '0 : hold_q - CNT_W'(1);
    assign gap_m1  = (gap_q  == '0) ? '0 : gap_q  - CNT_W'(1);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = PERIOD_M1;
        case (state)
            IDLE:       tmr_load = start;
            BOUNCE_IN: begin
                tmr_load = tmr_zero;
                if (seg_idx == LAST_SEG) tmr_val = hold_m1;
            end
            HOLD:       tmr_load = tmr_zero;
            BOUNCE_OUT: begin
                tmr_load = tmr_zero;
                if (seg_idx == LAST_SEG) tmr_val = gap_m1;
            end
            GAP:        tmr_load = tmr_zero;
            default:    tmr_load = 1'b0;
        endcase
    end

    button_press_gen_seg_timer #(
        .CNT_W (CNT_W)
    ) u_seg_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            seg_idx      <= '0;
            presses_left <= '0;
            hold_q       <= '0;
            gap_q        <= '0;
            button       <= 1'b0;
            press_active <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (abort) begin
            state        <= IDLE;
            button       <= 1'b0;
            press_active <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        hold_q       <= hold_cycles;
                        gap_q        <= gap_cycles;
                        presses_left <= num_presses;
                        seg_idx      <= '0;
                        if (num_presses == 4'd0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state  <= BOUNCE_IN;
                            button <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                end
                BOUNCE_IN: begin
                    if (tmr_zero) begin
                        if (seg_idx == LAST_SEG) begin
                            state        <= HOLD;
                            button       <= 1'b1;
                            press_active <= 1'b1;
                            seg_idx      <= '0;
                        end else begin
                            // Even segments are high on the way in.
                            seg_idx <= seg_idx + 5'd1;
                            button  <= seg_idx[0];
                        end
                    end
                end
                HOLD: begin
                    if (tmr_zero) begin
                        state        <= BOUNCE_OUT;
                        button       <= 1'b0;
                        press_active <= 1'b0;
                        seg_idx      <= '0;
                    end
                end
                BOUNCE_OUT: begin
                    if (tmr_zero) begin
                        if (seg_idx == LAST_SEG) begin
                            state   <= GAP;
                            button  <= 1'b0;
                            seg_idx <= '0;
                        end else begin
                            seg_idx <= seg_idx + 5'd1;
                            button  <= ~seg_idx[0];
                        end
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        presses_left <= presses_left - 4'd1;
                        if (presses_left == 4'd1) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state  <= BOUNCE_IN;
                            button <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    button       <= 1'b0;
                    press_active <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_button_press_gen.sv
// ============================================================================
// tb_button_press_gen : scoreboard bench for button_press_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_press_gen;

    localparam int CNT_W = 24;
    localparam int T     = 4;
    localparam int P     = 3;

    // Expected vector layout: {button, press_active, busy, done}
    localparam logic [3:0] V_IDLE = 4'b0000;
    localparam logic [3:0] V_HI   = 4'b1010;
    localparam logic [3:0] V_LO   = 4'b0010;
    localparam logic [3:0] V_HOLD = 4'b1110;
    localparam logic [3:0] V_DONE = 4'b0001;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] hold_cycles;
    logic [CNT_W-1:0] gap_cycles;
    logic [3:0]       num_presses;
    logic             button;
    logic             press_active;
    logic             busy;
    logic             done;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   b_base;
    int   b_k;
    int   b_cut;
    int   b_done_k;

    button_press_gen #(
        .CNT_W          (CNT_W),
        .BOUNCE_TOGGLES (T),
        .BOUNCE_PERIOD  (P)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .hold_cycles  (hold_cycles),
        .gap_cycles   (gap_cycles),
        .num_presses  (num_presses),
        .button       (button),
        .press_active (press_active),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: actual {button,press_active,busy,done}=%b required=%b",
                     name, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            check($sformatf("cycle %0d", mon_e.cyc), {button, press_active, busy, done}, mon_e.v);
        end
    end

    function automatic void push_exp(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endfunction

    // Vectors at or beyond the cut point become idle, and only a few are kept.
    function automatic void add(input logic [3:0] v);
        if (b_cut == 0 || b_k < b_cut)
            push_exp(b_base + b_k, v);
        else if (b_k < b_cut + 4)
            push_exp(b_base + b_k, V_IDLE);
        b_k++;
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: actual pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) push_exp(cyc + i, V_IDLE);
        wait_drain();
    endtask

    task automatic issue(input int hold, input int gap, input int num,
                         input int cut, input bit use_reset, input bit poke);
        int hl;
        int gl;
        @(posedge clk);
        #1;
        b_base      = cyc;
        b_k         = 1;
        b_cut       = cut;
        start       = 1'b1;
        hold_cycles = CNT_W'(hold);
        gap_cycles  = CNT_W'(gap);
        num_presses = 4'(num);
        hl = (hold == 0) ? 1 : hold;
        gl = (gap == 0) ? 1 : gap;
        for (int p = 0; p < num; p++) begin
            for (int s = 0; s < 2 * T; s++)
                for (int j = 0; j < P; j++) add((s % 2 == 0) ? V_HI : V_LO);
            for (int j = 0; j < hl; j++) add(V_HOLD);
            for (int s = 0; s < 2 * T; s++)
                for (int j = 0; j < P; j++) add((s % 2 == 1) ? V_HI : V_LO);
            for (int j = 0; j < gl; j++) add(V_LO);
        end
        b_done_k = b_k;
        add(V_DONE);
        for (int j = 0; j < 3; j++) add(V_IDLE);
        @(posedge clk);
        #1;
        start       = 1'b0;
        hold_cycles = CNT_W'($urandom_range(1000, 3));
        gap_cycles  = CNT_W'($urandom_range(1000, 3));
        num_presses = 4'hF;
        if (poke) begin
            wait_cyc(b_base + 5);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            // Start during the done cycle must also be ignored.
            wait_cyc(b_base + b_done_k);
            start       = 1'b1;
            num_presses = 4'd1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (cut != 0 && !use_reset) begin
            wait_cyc(b_base + cut - 1);
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
        if (cut != 0 && use_reset) begin
            wait_cyc(b_base + cut - 1);
            @(posedge clk);
            #2;
            rst = 1'b0;
            #1;
            check("async reset mid-HOLD", {button, press_active, busy, done}, V_IDLE);
            @(posedge clk);
            @(posedge clk);
            #2;
            rst = 1'b1;
        end
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        hold_cycles = '0;
        gap_cycles  = '0;
        num_presses = '0;
        #1;
        rst = 1'b0;
        #1;
        check("reset state", {button, press_active, busy, done}, V_IDLE);
        @(posedge clk);
        #2;
        rst = 1'b1;
        expect_idle(4);

        // Single press: done lands 64 cycles after the sampling edge.
        issue(10, 5, 1, 0, 1'b0, 1'b0);
        // Three short presses with start pokes while busy and during done.
        issue(2, 1, 3, 0, 1'b0, 1'b1);
        // No presses: only a done pulse one cycle after start.
        issue(7, 4, 0, 0, 1'b0, 1'b0);
        // Zero hold and gap each act as one cycle.
        issue(0, 0, 1, 0, 1'b0, 1'b0);
        // Abort in the middle of release bounce.
        issue(10, 5, 1, 40, 1'b0, 1'b0);
        expect_idle(10);

        // Abort together with start in IDLE: nothing is accepted.
        @(posedge clk);
        #1;
        start       = 1'b1;
        abort       = 1'b1;
        hold_cycles = CNT_W'(4);
        gap_cycles  = CNT_W'(4);
        num_presses = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        expect_idle(30);

        // Asynchronous reset during HOLD, then confirm no done follows.
        issue(10, 5, 1, 30, 1'b1, 1'b0);
        expect_idle(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
